morse_capture_seq: RTL and testbench

MORSE_CAPTURE_SEQ -- requirements
Module: morse_capture_seq

---
 rtl/morse_capture_seq_pkg.sv | 58 +++++
 rtl/morse_capture_seq_char.sv | 127 ++++++++++++
 rtl/morse_capture_seq.sv | 175 +++++++++++++++++
 tb/tb_morse_capture_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_capture_seq_pkg.sv
// Shared widths, state encodings, FIFO entry layout and timing helpers
// for the morse capture sequencer and its character capture core.
package morse_capture_seq_pkg;

    localparam int PULSE_CNT_W   = 8;
    localparam int MORSE_LEN_W   = 3;
    localparam int MAX_MORSE_LEN = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_WAIT,
        CAP_MARK,
        CAP_GAP,
        CAP_WGAP
    } cap_state_t;

    typedef struct packed {
        logic                     space;
        logic                     error;
        logic [MORSE_LEN_W-1:0]   len;
        logic [MAX_MORSE_LEN-1:0] dits_dahs;
    } fifo_entry_t;

    // Multiply by a small factor at full width, clamping to all-ones.
    function automatic logic [PULSE_CNT_W-1:0] scale_clamp(
        input logic [PULSE_CNT_W-1:0] dit,
        input logic [3:0]             k
    );
        logic [PULSE_CNT_W+3:0] wide;
        wide = {4'b0000, dit} * {{PULSE_CNT_W{1'b0}}, k};
        if (wide[PULSE_CNT_W+3:PULSE_CNT_W] != 4'b0000)
            return '1;
        return wide[PULSE_CNT_W-1:0];
    endfunction

    function automatic logic [PULSE_CNT_W-1:0] sat_inc(
        input logic [PULSE_CNT_W-1:0] v
    );
        if (v == '1)
            return v;
        return v + PULSE_CNT_W'(1);
    endfunction

    function automatic logic [PULSE_CNT_W-1:0] abs_diff(
        input logic [PULSE_CNT_W-1:0] a,
        input logic [PULSE_CNT_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/morse_capture_seq_char.sv
// Character capture core: measures marks and spaces in ce pulses, classifies
// elements as dit/dah and reports character or word ends through ceo.
module morse_capture_char
    import morse_capture_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     start,
    input  logic                     signal,
    input  logic [PULSE_CNT_W-1:0]   dit_time,
    input  logic [PULSE_CNT_W-1:0]   dah_time,
    input  logic [PULSE_CNT_W-1:0]   word_time,
    input  logic [PULSE_CNT_W-1:0]   tol,
    output logic                     ceo,
    output logic                     word_end,
    output logic                     error,
    output logic [MORSE_LEN_W-1:0]   len,
    output logic [MAX_MORSE_LEN-1:0] dits_dahs
);

    cap_state_t               state, state_n;
    logic [PULSE_CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [MORSE_LEN_W-1:0]   len_q, len_n;
    logic [MAX_MORSE_LEN-1:0] bits_q, bits_n;
    logic                     err_q, err_n;
    logic                     is_dit, is_dah;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CAP_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            bits_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            len_q  <= len_n;
            bits_q <= bits_n;
            err_q  <= err_n;
        end
    end

    // ceo is combinational so the sequencer can act in the same ce cycle;
    // a mark fitting neither window, or one element too many, flags the char.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        len_n    = len_q;
        bits_n   = bits_q;
        err_n    = err_q;
        ceo      = 1'b0;
        word_end = 1'b0;
        cnt_inc  = sat_inc(cnt);
        is_dit   = abs_diff(cnt, dit_time) <= tol;
        is_dah   = abs_diff(cnt, dah_time) <= tol;
        if (ce) begin
            if (start) begin
                state_n = CAP_WAIT;
                cnt_n   = '0;
                len_n   = '0;
                bits_n  = '0;
                err_n   = 1'b0;
            end else begin
                case (state)
                    CAP_WAIT: begin
                        if (signal) begin
                            state_n = CAP_MARK;
                            cnt_n   = PULSE_CNT_W'(1);
                        end
                    end
                    CAP_MARK: begin
                        if (signal) begin
                            cnt_n = cnt_inc;
                        end else begin
                            if (len_q == MORSE_LEN_W'(MAX_MORSE_LEN)) begin
                                err_n = 1'b1;
                            end else begin
                                len_n  = len_q + MORSE_LEN_W'(1);
                                bits_n = {bits_q[MAX_MORSE_LEN-2:0], is_dah & ~is_dit};
                                if (!is_dit && !is_dah)
                                    err_n = 1'b1;
                            end
                            state_n = CAP_GAP;
                            cnt_n   = PULSE_CNT_W'(1);
                        end
                    end
                    CAP_GAP: begin
                        if (signal) begin
                            state_n = CAP_MARK;
                            cnt_n   = PULSE_CNT_W'(1);
                        end else begin
                            cnt_n = cnt_inc;
                            if (cnt_inc >= dah_time) begin
                                ceo     = 1'b1;
                                state_n = CAP_WGAP;
                            end
                        end
                    end
                    CAP_WGAP: begin
                        if (signal) begin
                            state_n = CAP_MARK;
                            cnt_n   = PULSE_CNT_W'(1);
                            len_n   = '0;
                            bits_n  = '0;
                            err_n   = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                            if (cnt_inc >= word_time) begin
                                ceo      = 1'b1;
                                word_end = 1'b1;
                                state_n  = CAP_IDLE;
                            end
                        end
                    end
                    default: state_n = CAP_IDLE;
                endcase
            end
        end
    end

    assign error     = err_q;
    assign len       = len_q;
    assign dits_dahs = bits_q;

endmodule

// File: rtl/morse_capture_seq.sv
// Morse capture sequencer: arms the capture core, collects characters and
// word separators into a small result FIFO, tracks errors and overflow.
module morse_capture_seq
    import morse_capture_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIT_RST    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     enable,
    input  logic                     stop_on_err,
    input  logic                     cfg_we,
    input  logic [PULSE_CNT_W-1:0]   cfg_dit,
    input  logic                     signal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_space,
    output logic                     out_error,
    output logic [MORSE_LEN_W-1:0]   out_len,
    output logic [MAX_MORSE_LEN-1:0] out_dits_dahs,
    output logic [PULSE_CNT_W-1:0]   dit_time,
    output logic                     busy,
    output logic                     halted,
    output logic                     overflow,
    output logic [7:0]               err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    seq_state_t             state, state_n;
    logic [PULSE_CNT_W-1:0] dit_q, dah_time, word_time, tol_time;
    logic                   cap_start, cap_ceo, cap_word_end, cap_error;
    logic [MORSE_LEN_W-1:0] cap_len;
    logic [MAX_MORSE_LEN-1:0] cap_bits;
    logic                   push, pop, full, wr_en, clr_ovf, err_inc;
    fifo_entry_t            entry, head;
    fifo_entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;
    logic                   ovf_q;
    logic [7:0]             err_q;

    assign dah_time  = scale_clamp(dit_q, 4'd3);
    assign word_time = scale_clamp(dit_q, 4'd7);
    assign tol_time  = dit_q >> 1;
    assign cap_start = (state == ST_ARM);

    morse_capture_char u_char (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .start     (cap_start),
        .signal    (signal),
        .dit_time  (dit_q),
        .dah_time  (dah_time),
        .word_time (word_time),
        .tol       (tol_time),
        .ceo       (cap_ceo),
        .word_end  (cap_word_end),
        .error     (cap_error),
        .len       (cap_len),
        .dits_dahs (cap_bits)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // A zeroed entry is already a well-formed space token.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        clr_ovf = 1'b0;
        err_inc = 1'b0;
        entry   = '0;
        if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_n = ST_ARM;
                        clr_ovf = 1'b1;
                    end
                end
                ST_ARM: state_n = ST_RUN;
                ST_RUN: begin
                    if (!enable) begin
                        state_n = ST_IDLE;
                    end else if (cap_ceo) begin
                        push = 1'b1;
                        if (cap_word_end) begin
                            entry.space = 1'b1;
                            state_n     = ST_ARM;
                        end else begin
                            entry.error     = cap_error;
                            entry.len       = cap_len;
                            entry.dits_dahs = cap_bits;
                            if (cap_error) begin
                                err_inc = 1'b1;
                                if (stop_on_err)
                                    state_n = ST_HALT;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    if (!enable)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign pop   = out_valid && out_ready;
    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (!wr_en && pop)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: every read is qualified by a non-zero count.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dit_q <= PULSE_CNT_W'(DIT_RST);
            ovf_q <= 1'b0;
            err_q <= '0;
        end else begin
            if (ce && cfg_we && (cfg_dit != '0) && (state == ST_IDLE || state == ST_HALT))
                dit_q <= cfg_dit;
            if (clr_ovf)
                ovf_q <= 1'b0;
            else if (push && full && !pop)
                ovf_q <= 1'b1;
            if (err_inc && (err_q != 8'hFF))
                err_q <= err_q + 8'd1;
        end
    end

    assign head          = mem[rd_ptr];
    assign out_valid     = (count != '0);
    assign out_space     = out_valid ? head.space     : 1'b0;
    assign out_error     = out_valid ? head.error     : 1'b0;
    assign out_len       = out_valid ? head.len       : '0;
    assign out_dits_dahs = out_valid ? head.dits_dahs : '0;
    assign dit_time      = dit_q;
    assign busy          = (state == ST_ARM) || (state == ST_RUN);
    assign halted        = (state == ST_HALT);
    assign overflow      = ovf_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_morse_capture_seq.sv
// Directed bench for morse_capture_seq: keys morse patterns with known
// timing and compares FIFO entries and status against hand-derived values.
module tb_morse_capture_seq;
    import morse_capture_seq_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n, ce, enable, stop_on_err, cfg_we, signal, out_ready;
    logic [PULSE_CNT_W-1:0]   cfg_dit;
    logic                     out_valid, out_space, out_error, busy, halted, overflow;
    logic [MORSE_LEN_W-1:0]   out_len;
    logic [MAX_MORSE_LEN-1:0] out_dits_dahs;
    logic [PULSE_CNT_W-1:0]   dit_time;
    logic [7:0]               err_cnt;

    int checks = 0;
    int errors = 0;
    int dit = 10;
    int startCount = 0;
    int startMark;

    morse_capture_seq #(.FIFO_DEPTH(4), .DIT_RST(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .enable        (enable),
        .stop_on_err   (stop_on_err),
        .cfg_we        (cfg_we),
        .cfg_dit       (cfg_dit),
        .signal        (signal),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_space     (out_space),
        .out_error     (out_error),
        .out_len       (out_len),
        .out_dits_dahs (out_dits_dahs),
        .dit_time      (dit_time),
        .busy          (busy),
        .halted        (halted),
        .overflow      (overflow),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    // Count capture start pulses actually consumed by the core.
    always @(posedge clk) begin
        if (rst_n && ce && dut.cap_start)
            startCount <= startCount + 1;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            signal = 1'b1;
            ticks((pat[i] == "-") ? 3 * dit : dit);
            signal = 1'b0;
            ticks(dit);
        end
    endtask

    task automatic gap(input int n);
        signal = 1'b0;
        ticks(n);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid)
            checkOutput({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic popEntry(input string tag, input logic space, input logic err,
                            input int len, input int bits);
        waitValid(tag);
        checkOutput({tag, "_flags"}, {30'd0, out_space, out_error}, {30'd0, space, err});
        checkOutput({tag, "_len"}, 32'(out_len), 32'(len));
        checkOutput({tag, "_bits"}, 32'(out_dits_dahs), 32'(bits));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_fields"}, {22'd0, out_space, out_error, out_len, out_dits_dahs}, 32'd0);
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
        checkOutput({tag, "_dit"}, 32'(dit_time), 32'd10);
        checkOutput({tag, "_status"}, {30'd0, busy, halted}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; enable = 1'b0; stop_on_err = 1'b0;
        cfg_we = 1'b0; cfg_dit = '0; signal = 1'b0; out_ready = 1'b0;
        ticks(3);
        checkResetState("reset");
        checkOutput("reset_dah", 32'(dut.dah_time), 32'd30);
        checkOutput("reset_word", 32'(dut.word_time), 32'd70);
        checkOutput("reset_tol", 32'(dut.tol_time), 32'd5);
        rst_n = 1'b1;
        ticks(2);

        // Single character followed by a character gap
        enable = 1'b1;
        ticks(3);
        checkOutput("run_busy", 32'(busy), 32'd1);
        applyStimulus("--.-.");
        gap(25);
        waitValid("char1");
        ticks(3);
        checkOutput("char1_hold_len", 32'(out_len), 32'd5);
        popEntry("char1", 1'b0, 1'b0, 5, 6'b011010);

        // Character then word gap: entry, space token, one re-arm
        startMark = startCount;
        applyStimulus("...");
        gap(65);
        ticks(3);
        checkOutput("word_restart", 32'(startCount - startMark), 32'd1);
        popEntry("char2", 1'b0, 1'b0, 3, 0);
        popEntry("space", 1'b1, 1'b0, 0, 0);
        checkOutput("fifo_empty", 32'(out_valid), 32'd0);

        // Overflow: five characters into a four-entry FIFO
        applyStimulus(".");  gap(25);
        applyStimulus("-");  gap(25);
        applyStimulus(".."); gap(25);
        applyStimulus(".-"); gap(25);
        applyStimulus("-."); gap(70);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        popEntry("ovf_e0", 1'b0, 1'b0, 1, 0);
        popEntry("ovf_e1", 1'b0, 1'b0, 1, 1);
        popEntry("ovf_e2", 1'b0, 1'b0, 2, 0);
        popEntry("ovf_e3", 1'b0, 1'b0, 2, 1);
        checkOutput("ovf_drained", 32'(out_valid), 32'd0);
        enable = 1'b0;
        ticks(2);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        enable = 1'b1;
        ticks(3);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Configuration writes: ignored in RUN, accepted in IDLE, clamped
        cfg_we = 1'b1; cfg_dit = 8'd20;
        ticks(1);
        cfg_we = 1'b0;
        checkOutput("cfg_run_ignored", 32'(dit_time), 32'd10);
        enable = 1'b0;
        ticks(2);
        cfg_we = 1'b1;
        ticks(1);
        cfg_we = 1'b0;
        checkOutput("cfg_dit20", 32'(dit_time), 32'd20);
        checkOutput("cfg_dah60", 32'(dut.dah_time), 32'd60);
        checkOutput("cfg_word140", 32'(dut.word_time), 32'd140);
        checkOutput("cfg_tol10", 32'(dut.tol_time), 32'd10);
        cfg_we = 1'b1; cfg_dit = 8'd0;
        ticks(1);
        checkOutput("cfg_zero_ignored", 32'(dit_time), 32'd20);
        cfg_dit = 8'd250;
        ticks(1);
        checkOutput("cfg_word_clamp", 32'(dut.word_time), 32'd255);
        checkOutput("cfg_dah_clamp", 32'(dut.dah_time), 32'd255);
        checkOutput("cfg_tol125", 32'(dut.tol_time), 32'd125);
        cfg_dit = 8'd10;
        ticks(1);
        cfg_we = 1'b0;

        // Malformed mark with stop_on_err halts after one entry
        stop_on_err = 1'b1;
        enable = 1'b1;
        ticks(3);
        signal = 1'b1;
        ticks(18);
        gap(35);
        waitValid("err");
        checkOutput("err_flag", 32'(out_error), 32'd1);
        checkOutput("err_cnt1", 32'(err_cnt), 32'd1);
        checkOutput("err_halted", 32'(halted), 32'd1);
        out_ready = 1'b1;
        ticks(1);
        out_ready = 1'b0;
        applyStimulus(".");
        gap(80);
        checkOutput("halt_no_push", 32'(out_valid), 32'd0);
        cfg_we = 1'b1; cfg_dit = 8'd12;
        ticks(1);
        cfg_we = 1'b0;
        checkOutput("cfg_halt", 32'(dit_time), 32'd12);
        enable = 1'b0;
        ticks(2);
        checkOutput("halt_exit", {30'd0, busy, halted}, 32'd0);

        // Reset mid-character with the FIFO holding an entry
        dit = 12;
        stop_on_err = 1'b0;
        enable = 1'b1;
        ticks(3);
        applyStimulus(".");
        gap(30);
        waitValid("pre_reset");
        signal = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        enable = 1'b0;
        ticks(1);
        checkResetState("midreset");
        rst_n = 1'b1;
        signal = 1'b0;
        dit = 10;
        ticks(2);
        enable = 1'b1;
        ticks(3);
        applyStimulus("...");
        gap(25);
        popEntry("post_reset", 1'b0, 1'b0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
